square_note_gen: RTL

- Square-wave note synthesiser; the transmit-side counterpart of the note detector.
- Accepts a MIDI note number plus a note_on gate and drives a 1-bit square-wave audio line at that note's equal-tempered frequency (A4 = MIDI 69 = 440 Hz).
- Serves as the audio source for detector loopback benches and as the on-board tone output.
- Every note change is glitch-free: it takes effect only on a half-period boundary.

---
 rtl/square_note_pkg.sv | 24 ++
 rtl/note_period_rom.sv | 28 ++
 rtl/square_note_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/square_note_pkg.sv
// Shared types and constants for the square-wave note generator and its
// period lookup.
package square_note_pkg;

    typedef logic [6:0] midi_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    localparam int MIDI_A4 = 69;
    localparam int A4_HZ   = 440;

    // Half-period in clock cycles for MIDI note n, rounded to nearest.
    function automatic longint half_period(input int n, input longint f_clk);
        real freq;
        real cycles;
        freq   = real'(A4_HZ) * (2.0 ** (real'(n - MIDI_A4) / 12.0));
        cycles = real'(f_clk) / (2.0 * freq);
        return longint'($rtoi(cycles + 0.5));
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// Combinational MIDI-note to half-period lookup, 128 entries, built at
// elaboration from the equal-tempered tuning formula.
module note_period_rom
    import square_note_pkg::*;
#(
    parameter int F_CLK    = 12_000_000,
    parameter int HP_WIDTH = 20
) (
    input  midi_t               midi,
    output logic [HP_WIDTH-1:0] hp
);

    logic [HP_WIDTH-1:0] rom [128];

    for (genvar i = 0; i < 128; i++) begin : g_entry
        localparam longint HP_FULL = half_period(i, longint'(F_CLK));

        // A zero entry would stall the counter; an oversized one would wrap.
        if (HP_FULL < 64'sd1 || HP_FULL >= (longint'(1) << HP_WIDTH)) begin : g_bad
            $error("note_period_rom: half-period out of range for a table entry");
        end

        assign rom[i] = HP_WIDTH'(HP_FULL);
    end

    assign hp = rom[midi];

endmodule

// File: rtl/square_note_gen.sv
// Square-wave note synthesiser: plays the requested MIDI note as a 50% duty
// 1-bit waveform, switching pitch only on half-period boundaries.
module square_note_gen
    import square_note_pkg::*;
#(
    parameter int F_CLK    = 12_000_000,
    parameter int HP_WIDTH = 20
) (
    input  logic  clk,
    input  logic  reset,
    input  midi_t midi,
    input  logic  note_on,
    output logic  audio,
    output logic  active,
    output midi_t cur_midi
);

    state_t              state;
    state_t              state_next;
    logic [HP_WIDTH-1:0] cnt;
    logic [HP_WIDTH-1:0] cnt_next;
    logic [HP_WIDTH-1:0] hp;
    logic                audio_next;
    midi_t               cur_midi_next;

    note_period_rom #(
        .F_CLK    (F_CLK),
        .HP_WIDTH (HP_WIDTH)
    ) u_rom (
        .midi (midi),
        .hp   (hp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            audio    <= 1'b0;
            cnt      <= '0;
            cur_midi <= '0;
        end else begin
            state    <= state_next;
            audio    <= audio_next;
            cnt      <= cnt_next;
            cur_midi <= cur_midi_next;
        end
    end

    always_comb begin
        state_next    = state;
        audio_next    = audio;
        cnt_next      = cnt;
        cur_midi_next = cur_midi;
        unique case (state)
            IDLE: begin
                audio_next = 1'b0;
                if (note_on) begin
                    state_next    = PLAYING;
                    audio_next    = 1'b1;
                    cnt_next      = hp - HP_WIDTH'(1);
                    cur_midi_next = midi;
                end
            end
            PLAYING: begin
                if (!note_on && !audio) begin
                    // Released during a low phase: stop at once, line already low.
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    if (!note_on) begin
                        // Released high phase has completed: fall and stop.
                        state_next = IDLE;
                        audio_next = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        audio_next    = ~audio;
                        cnt_next      = hp - HP_WIDTH'(1);
                        cur_midi_next = midi;
                    end
                end else begin
                    cnt_next = cnt - HP_WIDTH'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        active = (state == PLAYING);
    end

endmodule
